clk_duty_monitor: RTL
=====================

CLK_DUTY_MONITOR -- requirements
Module: clk_duty_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the half-cycle counters and measurement fields.
REQ-002 Parameter LOCK_N, default 4: consecutive matching periods needed to assert locked.
REQ-003 Parameter ERR_W, default 8: width of the saturating error counter.
REQ-004 clk  input  1  reference clock; the monitored clock is derived from and synchronous to it.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  monitor enable, sampled on posedge clk.
REQ-007 div_in  input  1  divided clock under test, toggling on either edge of clk.
REQ-008 exp_period  input  CNT_W  expected period, in clk half-cycles.
REQ-009 exp_high  input  CNT_W  expected high time, in clk half-cycles.
REQ-010 meas_period  output  CNT_W  last completed period, in half-cycles.
REQ-011 meas_high  output  CNT_W  high time of the last completed period, in half-cycles.
REQ-012 meas_valid  output  1  one-cycle pulse when meas_* update.
REQ-013 mismatch  output  1  one-cycle pulse, coincident with meas_valid, when the measurement differs from expected.
REQ-014 timeout  output  1  one-cycle pulse when no rising edge occurs within 2^CNT_W-1 half-cycles.
REQ-015 locked  output  1  high after LOCK_N consecutive matching periods.
REQ-016 err_cnt  output  ERR_W  saturating count of mismatch plus timeout events.

Function
REQ-017 div_in shall be sampled on both clk edges; the negedge sample n_k shall be held and consumed at posedge k, giving the ordered sample stream ..., p_(k-1), n_k, p_k.
REQ-018 A rising edge is a 0->1 transition between adjacent stream samples; at most one is possible per clk cycle, and the logic shall rely on that.
REQ-019 A period spans successive rising edges; meas_period counts its samples and meas_high counts its 1-samples (each 1-sample adds one half-cycle).
REQ-020 The FSM shall have three states: IDLE, ARM and MEASURE.
REQ-021 IDLE -> ARM when en=1.
REQ-022 ARM -> MEASURE on the first rising edge; the partial period before that edge shall produce no meas_valid.
REQ-023 MEASURE: at each rising edge, meas_* shall update and meas_valid shall pulse in the same posedge that detects the edge; counters restart from the post-edge samples.
REQ-024 mismatch = meas_valid & (meas_period != exp_period | meas_high != exp_high), compared exactly.
REQ-025 The period counter shall saturate at 2^CNT_W-1; on reaching it, timeout shall pulse, the FSM shall go to ARM, and no meas_valid shall be issued.
REQ-026 locked shall rise in the cycle of the LOCK_N-th consecutive matching meas_valid.
REQ-027 locked shall clear in the same cycle as any mismatch, timeout, or en=0.
REQ-028 en=0 in any state shall force IDLE within one cycle, clear locked and the match run count, and hold meas_* and err_cnt.
REQ-029 err_cnt shall increment by 1 per mismatch or timeout cycle and saturate at 2^ERR_W-1.
REQ-030 Changes to exp_* take effect on the next comparison; no resynchronisation is required.

Reset
REQ-031 While rst=1, posedge state shall be: FSM=IDLE, meas_period=0, meas_high=0, err_cnt=0, run count 0, held negedge sample 0.
REQ-032 While rst=1, meas_valid, mismatch, timeout and locked shall be 0.
REQ-033 The negedge sampler shall clear on negedge while rst=1.
REQ-034 Reset asserted mid-period shall discard the partial measurement and emit no pulse.

Structure
REQ-035 Package clk_mon_pkg shall hold the FSM state enum and defaults for CNT_W, ERR_W and LOCK_N.
REQ-036 Sub-module dual_edge_sampler shall produce the sample pair (n_k, p_k) and the per-cycle rise flag and position; all other logic is posedge only.

Verification
REQ-037 Div-by-3 50% source (period 6, high 3), exp=6/3, en=1 -> meas_valid every 3 cycles with 6/3, no mismatch; locked at the 4th valid.
REQ-038 Div-by-3 posedge-only source (high 2), exp=6/3 -> mismatch on every valid, meas_high=2, locked=0, err_cnt counts up.
REQ-039 div_in stuck at 0 with CNT_W=4 -> timeout pulse after 15 half-cycles without a rise; the FSM re-arms and timeout repeats.
REQ-040 Locked, then one stretched period (8/5) -> mismatch and locked=0 in the same cycle; locked reasserts after 4 further good periods.
REQ-041 rst pulse mid-period, or en dropped for 1 cycle -> no meas_valid for the partial period; the first valid follows the second rise after recovery.
REQ-042 Force more than 255 errors -> err_cnt holds at 255.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared FSM state type and parameter defaults for clk_duty_monitor.
// Contents:
//   CNT_W_DEF  - default width of the half-cycle counters and measurement fields
//   ERR_W_DEF  - default width of the saturating error counter
//   LOCK_N_DEF - default number of consecutive matching periods needed for lock
//   state_e    - monitor FSM states (IDLE, ARM, MEASURE)
package clk_mon_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int ERR_W_DEF  = 8;
    localparam int LOCK_N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_e;

endpackage

// File: rtl/clk_duty_monitor_if.sv
// clk_duty_monitor_if: control, expectation and result signals of clk_duty_monitor.
// Signals:
//   en          - monitor enable
//   div_in      - divided clock under test
//   exp_period  - expected period, in clk half-cycles
//   exp_high    - expected high time, in clk half-cycles
//   meas_period - last completed period, in half-cycles
//   meas_high   - high time of the last completed period
//   meas_valid  - one-cycle pulse when meas_* update
//   mismatch    - one-cycle pulse when the measurement differs from expected
//   timeout     - one-cycle pulse when no rising edge arrives in time
//   locked      - high after enough consecutive matching periods
//   err_cnt     - saturating count of mismatch and timeout events
// Modports: master drives the stimulus side, slave is the monitor.
interface clk_duty_monitor_if #(
    parameter int CNT_W = clk_mon_pkg::CNT_W_DEF,
    parameter int ERR_W = clk_mon_pkg::ERR_W_DEF
);

    logic             en;
    logic             div_in;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] exp_high;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic             mismatch;
    logic             timeout;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, div_in, exp_period, exp_high,
        input  meas_period, meas_high, meas_valid, mismatch, timeout, locked, err_cnt
    );

    modport slave (
        input  en, div_in, exp_period, exp_high,
        output meas_period, meas_high, meas_valid, mismatch, timeout, locked, err_cnt
    );

endinterface

// File: rtl/dual_edge_sampler.sv
// dual_edge_sampler: samples div_in on both clk edges and flags the rising edge in each cycle.
// Ports:
//   clk       - reference clock
//   rst       - synchronous active-high reset (also clears the negedge sample)
//   div_in    - divided clock under test
//   n_smp     - negedge sample n_k, held for the following posedge
//   p_smp     - posedge sample p_k (div_in as seen at the consuming posedge)
//   rise      - a 0->1 transition lies inside the stream p_(k-1), n_k, p_k
//   rise_at_p - the transition lands on p_k (otherwise on n_k)
module dual_edge_sampler (
    input  logic clk,
    input  logic rst,
    input  logic div_in,
    output logic n_smp,
    output logic p_smp,
    output logic rise,
    output logic rise_at_p
);

    logic n_q, n_d;
    logic p_q, p_d;

    always_comb begin
        n_d = rst ? 1'b0 : div_in;
        p_d = rst ? 1'b0 : div_in;
    end

    always_ff @(negedge clk) n_q <= n_d;

    always_ff @(posedge clk) p_q <= p_d;

    // Both transitions cannot coexist: a rise on n_k leaves n_k=1, which blocks a rise on p_k.
    assign n_smp     = n_q;
    assign p_smp     = div_in;
    assign rise_at_p = !n_q && div_in;
    assign rise      = (!p_q && n_q) || rise_at_p;

endmodule

// File: rtl/clk_duty_monitor.sv
// clk_duty_monitor: measures period and high time of a clk-derived divided clock in clk
// half-cycles, compares against expected values, tracks lock and counts errors.
// Ports:
//   clk - reference clock
//   rst - synchronous active-high reset
//   bus - clk_duty_monitor_if slave: en, div_in, exp_* in; meas_*, mismatch, timeout,
//         locked, err_cnt out (all outputs registered)
module clk_duty_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LOCK_N = LOCK_N_DEF,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    clk_duty_monitor_if.slave   bus
);

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic n_smp, p_smp, rise, rise_at_p;

    dual_edge_sampler u_sampler (
        .clk       (clk),
        .rst       (rst),
        .div_in    (bus.div_in),
        .n_smp     (n_smp),
        .p_smp     (p_smp),
        .rise      (rise),
        .rise_at_p (rise_at_p)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d;
    logic [CNT_W-1:0] meas_high_q, meas_high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             mismatch_q, mismatch_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] pend_period, pend_high, cnt_post, hcnt_post;
    logic [ERR_W-1:0] err_inc;
    logic             match;

    // cnt_q holds at most CNT_MAX-1 samples, so closing a period never overflows.
    assign cnt_sum     = {1'b0, cnt_q} + (CNT_W+1)'(2);
    assign pend_period = cnt_q + CNT_W'(rise_at_p);
    // A rise on p_k implies n_k=0, so n_k never adds to the closing high time.
    assign pend_high   = hcnt_q;
    assign cnt_post    = rise_at_p ? CNT_W'(1) : CNT_W'(2);
    assign hcnt_post   = rise_at_p ? CNT_W'(1) : CNT_W'(1) + CNT_W'(p_smp);
    assign match       = pend_period == bus.exp_period && pend_high == bus.exp_high;
    assign err_inc     = &err_q ? err_q : err_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hcnt_d        = hcnt_q;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        meas_valid_d  = 1'b0;
        mismatch_d    = 1'b0;
        timeout_d     = 1'b0;
        locked_d      = locked_q;
        run_d         = run_q;
        err_d         = err_q;
        if (rst) begin
            state_d       = IDLE;
            cnt_d         = '0;
            hcnt_d        = '0;
            meas_period_d = '0;
            meas_high_d   = '0;
            locked_d      = 1'b0;
            run_d         = '0;
            err_d         = '0;
        end else if (!bus.en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            locked_d = 1'b0;
            run_d    = '0;
        end else if (state_q == IDLE) begin
            state_d = ARM;
            cnt_d   = '0;
            hcnt_d  = '0;
        end else if (rise) begin
            state_d = MEASURE;
            cnt_d   = cnt_post;
            hcnt_d  = hcnt_post;
            // In ARM the span before this edge is a partial period and is dropped.
            if (state_q == MEASURE) begin
                meas_period_d = pend_period;
                meas_high_d   = pend_high;
                meas_valid_d  = 1'b1;
                mismatch_d    = !match;
                run_d         = !match ? '0 : (run_q == RUN_W'(LOCK_N)) ? run_q : run_q + 1'b1;
                locked_d      = match && (locked_q || run_q == RUN_W'(LOCK_N - 1));
                err_d         = match ? err_q : err_inc;
            end
        end else if (cnt_sum >= CNT_MAX) begin
            state_d   = ARM;
            cnt_d     = '0;
            hcnt_d    = '0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            run_d     = '0;
            err_d     = err_inc;
        end else begin
            cnt_d  = cnt_sum[CNT_W-1:0];
            hcnt_d = hcnt_q + CNT_W'(n_smp) + CNT_W'(p_smp);
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        cnt_q         <= cnt_d;
        hcnt_q        <= hcnt_d;
        meas_period_q <= meas_period_d;
        meas_high_q   <= meas_high_d;
        meas_valid_q  <= meas_valid_d;
        mismatch_q    <= mismatch_d;
        timeout_q     <= timeout_d;
        locked_q      <= locked_d;
        run_q         <= run_d;
        err_q         <= err_d;
    end

    assign bus.meas_period = meas_period_q;
    assign bus.meas_high   = meas_high_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.mismatch    = mismatch_q;
    assign bus.timeout     = timeout_q;
    assign bus.locked      = locked_q;
    assign bus.err_cnt     = err_q;

endmodule
